// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and presents {if_valid, if_pc, if_instr} to decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  typedef enum logic [1:0] {
    START = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        flush_pending_q, flush_pending_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        valid_d;
  logic [31:0] out_pc_d, out_instr_d;

  logic        redirect;
  logic [31:0] target;

  // Encoding 11 is reserved and behaves like sequential fetch.
  assign redirect  = (branch == 2'b01) || (branch == 2'b10);
  assign target    = {branch_target[31:1], 1'b0};

  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redir_d         = redir_q;
    flush_pending_d = flush_pending_q;
    hold_pc_d       = hold_pc_q;
    hold_instr_d    = hold_instr_q;
    valid_d         = if_valid;
    out_pc_d        = if_pc;
    out_instr_d     = if_instr;

    // A redirect always turns the output into a bubble, even under stall.
    if (redirect) begin
      valid_d     = 1'b0;
      out_instr_d = NOP_INSTR;
    end

    case (state_q)
      START: begin
        state_d = REQ;
        if (redirect) begin
          pc_d = target;
        end else if (!stall) begin
          valid_d     = 1'b0;
          out_instr_d = NOP_INSTR;
        end
      end

      REQ: begin
        if (imem_rvalid) begin
          if (flush_pending_q || redirect) begin
            // Wrong-path data: drop it and restart at the newest redirect target.
            pc_d            = (flush_pending_q && !redirect) ? redir_q : target;
            flush_pending_d = 1'b0;
            if (!redirect && !stall) begin
              valid_d     = 1'b0;
              out_instr_d = NOP_INSTR;
            end
          end else if (!stall) begin
            valid_d     = 1'b1;
            out_pc_d    = pc_q;
            out_instr_d = imem_rdata;
            pc_d        = pc_q + 32'd4;
          end else begin
            hold_pc_d    = pc_q;
            hold_instr_d = imem_rdata;
            pc_d         = pc_q + 32'd4;
            state_d      = HOLD;
          end
        end else begin
          if (redirect) begin
            // The address must stay put until rvalid, so remember where to go.
            flush_pending_d = 1'b1;
            redir_d         = target;
          end else if (!stall) begin
            valid_d     = 1'b0;
            out_instr_d = NOP_INSTR;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!stall) begin
          valid_d     = 1'b1;
          out_pc_d    = hold_pc_q;
          out_instr_d = hold_instr_q;
          state_d     = REQ;
        end
      end

      default: begin
        state_d = START;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= START;
      pc_q            <= RESET_PC;
      redir_q         <= 32'h0;
      flush_pending_q <= 1'b0;
      hold_pc_q       <= 32'h0;
      hold_instr_q    <= 32'h0;
      if_valid        <= 1'b0;
      if_pc           <= 32'h0;
      if_instr        <= NOP_INSTR;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      redir_q         <= redir_d;
      flush_pending_q <= flush_pending_d;
      hold_pc_q       <= hold_pc_d;
      hold_instr_q    <= hold_instr_d;
      if_valid        <= valid_d;
      if_pc           <= out_pc_d;
      if_instr        <= out_instr_d;
    end
  end

  // The request address may not move while a read is still outstanding.
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req && !imem_rvalid) |=> (imem_req && $stable(imem_addr)));

  a_no_req_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD) |-> !imem_req);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table, hand-written reset/wrap
// sequences, then randomized traffic checked against a fetch-stream model.
module tb_instr_fetch;

  localparam logic [31:0] KEY         = 32'hA5A5_0000;
  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC     = 32'hFFFF_FFFC;
  localparam int          RAND_CYCLES = 3000;
  localparam int          NUM_VECS    = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  branch = 2'b00;
  logic [31:0] branch_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_instr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch       (branch),
    .branch_target(branch_target),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  // Second instance with a memory that answers every cycle, for the PC wrap case.
  assign w_rdata = w_addr ^ KEY;

  instr_fetch #(.RESET_PC(WRAP_PC)) wrap_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch       (2'b00),
    .branch_target(32'h0),
    .stall        (1'b0),
    .imem_req     (w_req),
    .imem_addr    (w_addr),
    .imem_rvalid  (1'b1),
    .imem_rdata   (w_rdata),
    .if_valid     (w_valid),
    .if_pc        (w_pc),
    .if_instr     (w_instr)
  );

  typedef struct {
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        stall;
    logic [1:0]  branch;
    logic [31:0] target;
    logic        rvalid;
  } vec_t;

  vec_t vecs[NUM_VECS];

  function automatic vec_t mk(input logic req, input logic [31:0] addr, input logic v,
                              input logic [31:0] pc, input logic [31:0] instr,
                              input logic s, input logic [1:0] b, input logic [31:0] t,
                              input logic rv);
    vec_t r;
    r.exp_req = req; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc; r.exp_instr = instr;
    r.stall = s; r.branch = b; r.target = t; r.rvalid = rv;
    return r;
  endfunction

  task automatic applyStimulus(input logic s, input logic [1:0] b, input logic [31:0] t,
                               input logic rv, input logic [31:0] rd);
    stall         = s;
    branch        = b;
    branch_target = t;
    imem_rvalid   = rv;
    imem_rdata    = rd;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Random-phase model state: the address decode must see next, plus memory timing.
  logic [31:0] expected_next;
  logic [31:0] tgt;
  logic [1:0]  br;
  logic        st, rv, is_redir;
  logic        have_prev, prev_stall, prev_redirect, prev_req, prev_rvalid;
  logic [64:0] prev_out;
  logic [31:0] prev_addr;
  int          age, lat, consumed;

  initial begin
    // Reset state of both instances.
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {imem_req, imem_addr, if_valid, if_pc, if_instr},
                {1'b0, 32'h0, 1'b0, 32'h0, NOP});
    checkOutput("wrap_reset_addr", {w_req, w_addr}, {1'b0, WRAP_PC});

    vecs[0]  = mk(1'b0, 32'h000, 1'b0, 32'h000, NOP,               1'b0, 2'b00, 32'h0,   1'b0);
    vecs[1]  = mk(1'b1, 32'h000, 1'b0, 32'h000, NOP,               1'b0, 2'b00, 32'h0,   1'b1);
    vecs[2]  = mk(1'b1, 32'h004, 1'b1, 32'h000, KEY ^ 32'h000,     1'b0, 2'b00, 32'h0,   1'b1);
    vecs[3]  = mk(1'b1, 32'h008, 1'b1, 32'h004, KEY ^ 32'h004,     1'b0, 2'b00, 32'h0,   1'b1);
    vecs[4]  = mk(1'b1, 32'h00C, 1'b1, 32'h008, KEY ^ 32'h008,     1'b0, 2'b00, 32'h0,   1'b1);
    vecs[5]  = mk(1'b1, 32'h010, 1'b1, 32'h00C, KEY ^ 32'h00C,     1'b1, 2'b00, 32'h0,   1'b1);
    vecs[6]  = mk(1'b0, 32'h014, 1'b1, 32'h00C, KEY ^ 32'h00C,     1'b1, 2'b00, 32'h0,   1'b0);
    vecs[7]  = mk(1'b0, 32'h014, 1'b1, 32'h00C, KEY ^ 32'h00C,     1'b1, 2'b00, 32'h0,   1'b0);
    vecs[8]  = mk(1'b0, 32'h014, 1'b1, 32'h00C, KEY ^ 32'h00C,     1'b0, 2'b00, 32'h0,   1'b0);
    vecs[9]  = mk(1'b1, 32'h014, 1'b1, 32'h010, KEY ^ 32'h010,     1'b0, 2'b00, 32'h0,   1'b0);
    vecs[10] = mk(1'b1, 32'h014, 1'b0, 32'h010, NOP,               1'b0, 2'b01, 32'h101, 1'b0);
    vecs[11] = mk(1'b1, 32'h014, 1'b0, 32'h010, NOP,               1'b0, 2'b00, 32'h0,   1'b1);
    vecs[12] = mk(1'b1, 32'h100, 1'b0, 32'h010, NOP,               1'b0, 2'b00, 32'h0,   1'b1);
    vecs[13] = mk(1'b1, 32'h104, 1'b1, 32'h100, KEY ^ 32'h100,     1'b1, 2'b10, 32'h40,  1'b1);
    vecs[14] = mk(1'b1, 32'h040, 1'b0, 32'h100, NOP,               1'b0, 2'b00, 32'h0,   1'b1);
    vecs[15] = mk(1'b1, 32'h044, 1'b1, 32'h040, KEY ^ 32'h040,     1'b0, 2'b00, 32'h0,   1'b0);
    vecs[16] = mk(1'b1, 32'h044, 1'b0, 32'h040, NOP,               1'b0, 2'b11, 32'h200, 1'b1);
    vecs[17] = mk(1'b1, 32'h048, 1'b1, 32'h044, KEY ^ 32'h044,     1'b0, 2'b00, 32'h0,   1'b0);
    vecs[18] = mk(1'b1, 32'h048, 1'b0, 32'h044, NOP,               1'b0, 2'b00, 32'h0,   1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NUM_VECS; i++) begin
      checkOutput($sformatf("vec%0d", i),
                  {imem_req, imem_addr, if_valid, if_pc, if_instr},
                  {vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc,
                   vecs[i].exp_instr});
      applyStimulus(vecs[i].stall, vecs[i].branch, vecs[i].target, vecs[i].rvalid,
                    vecs[i].exp_addr ^ KEY);
      @(negedge clk);
    end

    // Asynchronous reset between edges while a request is outstanding.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {imem_req, imem_addr, if_valid, if_pc, if_instr},
                {1'b0, 32'h0, 1'b0, 32'h0, NOP});
    applyStimulus(1'b0, 2'b00, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("restart_idle", {imem_req, imem_addr}, {1'b0, 32'h0});
    checkOutput("wrap_idle", {w_req, w_addr}, {1'b0, WRAP_PC});
    @(negedge clk);
    checkOutput("restart_req", {imem_req, imem_addr}, {1'b1, 32'h0});
    checkOutput("wrap_first_req", {w_req, w_addr}, {1'b1, WRAP_PC});
    @(negedge clk);
    checkOutput("wrap_to_zero", {w_addr, w_valid, w_pc, w_instr},
                {32'h0, 1'b1, WRAP_PC, WRAP_PC ^ KEY});
    @(negedge clk);
    checkOutput("wrap_next", {w_addr, w_valid, w_pc, w_instr},
                {32'h4, 1'b1, 32'h0, KEY});

    // Randomized traffic: decode must see the program order implied by redirects.
    expected_next = 32'h0;
    have_prev = 1'b0;
    prev_rvalid = 1'b0;
    prev_req = 1'b0;
    age = 0;
    lat = 1;
    consumed = 0;
    for (int c = 0; c < RAND_CYCLES; c++) begin
      if (have_prev) begin
        if (prev_redirect)
          checkOutput("bubble_after_redirect", {if_valid, if_instr}, {1'b0, NOP});
        else if (prev_stall)
          checkOutput("held_under_stall", {if_valid, if_pc, if_instr}, prev_out);
        if (prev_req && !prev_rvalid)
          checkOutput("addr_stable", {imem_req, imem_addr}, {1'b1, prev_addr});
      end

      st = ($urandom_range(0, 9) < 3);
      if (c >= 2 && $urandom_range(0, 15) == 0)
        br = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      else
        br = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'b00;
      tgt = $urandom;
      is_redir = (br == 2'b01) || (br == 2'b10);

      if (if_valid && !st) begin
        checkOutput("consume_pc", if_pc, expected_next);
        checkOutput("consume_instr", if_instr, expected_next ^ KEY);
        consumed++;
        expected_next = if_pc + 32'd4;
      end
      if (is_redir)
        expected_next = {tgt[31:1], 1'b0};

      if (prev_req && prev_rvalid)
        age = 0;
      if (imem_req) begin
        if (age == 0)
          lat = $urandom_range(1, 3);
        age++;
        rv = (age >= lat);
      end else begin
        age = 0;
        rv = 1'b0;
      end

      prev_out      = {if_valid, if_pc, if_instr};
      prev_stall    = st;
      prev_redirect = is_redir;
      prev_req      = imem_req;
      prev_rvalid   = rv;
      prev_addr     = imem_addr;
      have_prev     = 1'b1;
      applyStimulus(st, br, tgt, rv, rv ? (imem_addr ^ KEY) : $urandom);
      @(negedge clk);
    end
    checkOutput("progress", {31'b0, consumed >= 200}, {31'b0, 1'b1});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage of the RISC-V core; the producer of `pc` and the consumer of the `branch` / `alu_result` redirect pair driven by `execute`.
- Holds the PC and issues single-outstanding word reads to instruction memory over a req/rvalid handshake.
- Presents `{if_valid, if_pc, if_instr}` to decode.
- Applies `execute` redirects with priority over stalls and squashes wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, value driven on if_instr during reset and bubbles (addi x0,x0,0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
branch  in  2  PC mux select from execute: 00 sequential, 01 branch taken, 10 jump, 11 reserved (treated as 00)
branch_target  in  32  redirect target (execute alu_result)
stall  in  1  decode cannot accept; output register holds
imem_req  out  1  read request valid
imem_addr  out  32  word address of request
imem_rvalid  in  1  read data valid; completes the outstanding request
imem_rdata  in  32  instruction word
if_valid  out  1  if_pc/if_instr hold a valid instruction
if_pc  out  32  PC of presented instruction
if_instr  out  32  presented instruction

Behaviour:
- Clock and reset: single clock `clk`. `rst_n` is asynchronous, active-low.
- Reset values: state=START; pc_q=RESET_PC; flush_pending=0; imem_req=0; imem_addr=RESET_PC; if_valid=0; if_pc=0; if_instr=NOP_INSTR; hold regs=0.
- Assertion mid-operation: clears all state immediately; any outstanding memory request is abandoned.
- Redirect: redirect = (branch==01 || branch==10). Target = {branch_target[31:1],1'b0}; bit 1 passes through, with no misalignment trap.
- Memory protocol:
  - imem_addr = pc_q (combinational from register).
  - While imem_req=1 and rvalid not yet seen, imem_addr is stable.
  - The rvalid cycle completes the request; if imem_req is high in the next cycle, that is a new request.
  - Minimum latency is 1 cycle; throughput is 1 instr/cycle when memory returns rvalid every cycle.
- FSM:
  - START: imem_req=0; next state REQ. This gives exactly one idle cycle after reset release.
  - REQ: imem_req=1.
    - rvalid && (flush_pending || redirect): discard rdata; pc_q<=flush_pending&&!redirect ? redir_q : target; clear flush_pending; stay REQ.
    - rvalid, no flush, stall=0: if_valid<=1, if_pc<=pc_q, if_instr<=rdata, pc_q<=pc_q+4; stay REQ.
    - rvalid, no flush, stall=1: hold_pc<=pc_q, hold_instr<=rdata, pc_q<=pc_q+4; go HOLD.
    - No rvalid, redirect: flush_pending<=1, redir_q<=target. A later redirect overwrites redir_q.
    - No rvalid, stall=0: if_valid<=0, if_instr<=NOP_INSTR.
  - HOLD: imem_req=0.
    - redirect: drop hold, pc_q<=target; go REQ.
    - stall=0 (no redirect): outputs<=hold regs, if_valid<=1; go REQ.
- Output register:
  - When stall=1, if_valid/if_pc/if_instr are held.
  - Any redirect forces if_valid<=0 and if_instr<=NOP_INSTR next cycle regardless of stall; redirect beats stall.
  - if_pc is not cleared on bubbles.
- Arithmetic: pc_q+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Branch 11 is ignored, same as 00.
- An instruction fetched from a redirect target is never discarded by that same redirect.

Test Plan:
- Sequential fetch: reset release, memory returns rdata=addr^32'hA5A5_0000 with 1-cycle rvalid -> imem_req rises on cycle 2, then if_pc = 0,4,8,… with matching if_instr on consecutive cycles, and if_valid=1 from the first rvalid+1.
- Stall/hold: stall=1 for 3 cycles while rvalid returns addr 0x10 -> HOLD entered, imem_req=0, outputs frozen at the previous instr; on stall=0, if_pc=0x10 appears exactly next cycle with no loss or duplication.
- Redirect with outstanding request: branch=01, branch_target=0x101 while a 3-cycle-latency read of 0x20 is pending -> the 0x20 data is discarded, the next imem_addr=0x100, and if_valid=0 until the 0x100 instruction arrives.
- Simultaneous redirect+rvalid+stall: branch=10, target=0x40, rvalid=1, stall=1 in the same cycle -> rdata discarded, if_valid<=0, next imem_addr=0x40.
- Wrap: RESET_PC=32'hFFFF_FFFC -> fetch 0xFFFFFFFC, then 0x00000000.
- Async reset mid-fetch: rst_n low between clock edges during REQ -> imem_req=0, if_valid=0, if_instr=32'h13 immediately (no clock); after release, the fetch restarts at RESET_PC.
